// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pkg
//  Description : Shared state, mode and width definitions for the LED
//                sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package led_pkg;

    localparam int LED_W_DEF = 4;

    typedef logic [1:0] state_t;
    typedef logic [2:0] mode_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_HOLD = 2'd3;

    localparam mode_t MODE_STOP  = 3'd0;
    localparam mode_t MODE_SHL   = 3'd1;
    localparam mode_t MODE_SHR   = 3'd2;
    localparam mode_t MODE_PING  = 3'd3;
    localparam mode_t MODE_BLINK = 3'd4;
    localparam mode_t MODE_CNT   = 3'd5;

    // Reserved encodings (6, 7) behave like STOP.
    function automatic logic mode_is_run(input mode_t mode);
        return (mode >= MODE_SHL) && (mode <= MODE_CNT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Prescaler producing a one-cycle tick at TICK_HZ while enabled.
//  Revision    : 1.0  initial release
// ============================================================================
module tick_gen #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TICK_HZ  = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int C_DIV   = (CLK_FREQ / TICK_HZ < 1) ? 1 : CLK_FREQ / TICK_HZ;
    localparam int C_CNT_W = (C_DIV > 1) ? $clog2(C_DIV) : 1;
    localparam logic [C_CNT_W-1:0] C_TERM = C_CNT_W'(C_DIV - 1);

    logic [C_CNT_W-1:0] r_cnt_q;
    logic [C_CNT_W-1:0] w_cnt_d;
    logic               w_tick;

    always_comb begin
        w_cnt_d = r_cnt_q;
        w_tick  = 1'b0;
        if (en && !rst) begin
            if (r_cnt_q == C_TERM) begin
                w_cnt_d = '0;
                w_tick  = 1'b1;
            end else begin
                w_cnt_d = r_cnt_q + C_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign tick = w_tick;

endmodule
`default_nettype wire

// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_seq_ctrl
//  Description : Command-driven LED pattern sequencer with ms prescaler,
//                per-step period counter and pause/hold support.
//  Revision    : 1.0  initial release
// ============================================================================
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int LED_W    = LED_W_DEF,
    parameter int PER_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             pause,
    output logic [LED_W-1:0] led,
    output logic             step_pulse,
    output logic             busy
);
    localparam logic [LED_W-1:0] C_LED_LSB = LED_W'(1);
    localparam logic [LED_W-1:0] C_LED_MSB = C_LED_LSB << (LED_W - 1);

    state_t             r_state_q,      w_state_d;
    mode_t              r_mode_q,       w_mode_d;
    logic [PER_W-1:0]   r_period_q,     w_period_d;
    logic [PER_W-1:0]   r_per_cnt_q,    w_per_cnt_d;
    logic               r_dir_q,        w_dir_d;
    logic [LED_W-1:0]   r_led_q,        w_led_d;
    logic               r_step_pulse_q, w_step_pulse_d;
    logic               r_busy_q,       w_busy_d;
    logic               r_cmd_ready_q,  w_cmd_ready_d;

    logic               w_tick;
    logic               w_tick_en;
    logic               w_tick_clr;
    logic               w_step;
    logic               w_accept;
    logic [LED_W-1:0]   w_led_init;
    logic [LED_W-1:0]   w_led_next;
    logic               w_dir_next;

    assign w_accept   = cmd_valid && r_cmd_ready_q;
    assign w_tick_en  = (r_state_q == ST_RUN) && !pause;
    assign w_tick_clr = rst || (r_state_q == ST_LOAD);

    tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (w_tick_clr),
        .en   (w_tick_en),
        .tick (w_tick)
    );

    always_comb begin
        case (r_mode_q)
            MODE_SHL, MODE_PING: w_led_init = C_LED_LSB;
            MODE_SHR:            w_led_init = C_LED_MSB;
            MODE_BLINK:          w_led_init = '1;
            default:             w_led_init = '0;
        endcase
    end

    // r_dir_q = 1 walks toward the MSB; ends reverse without repeating.
    always_comb begin
        w_led_next = r_led_q;
        w_dir_next = r_dir_q;
        case (r_mode_q)
            MODE_SHL:   w_led_next = {r_led_q[LED_W-2:0], r_led_q[LED_W-1]};
            MODE_SHR:   w_led_next = {r_led_q[0], r_led_q[LED_W-1:1]};
            MODE_PING: begin
                if (r_dir_q) begin
                    if (r_led_q == C_LED_MSB) begin
                        w_led_next = r_led_q >> 1;
                        w_dir_next = 1'b0;
                    end else begin
                        w_led_next = r_led_q << 1;
                    end
                end else begin
                    if (r_led_q == C_LED_LSB) begin
                        w_led_next = r_led_q << 1;
                        w_dir_next = 1'b1;
                    end else begin
                        w_led_next = r_led_q >> 1;
                    end
                end
            end
            MODE_BLINK: w_led_next = ~r_led_q;
            MODE_CNT:   w_led_next = r_led_q + C_LED_LSB;
            default:    w_led_next = r_led_q;
        endcase
    end

    always_comb begin
        w_state_d      = r_state_q;
        w_mode_d       = r_mode_q;
        w_period_d     = r_period_q;
        w_per_cnt_d    = r_per_cnt_q;
        w_dir_d        = r_dir_q;
        w_led_d        = r_led_q;
        w_step_pulse_d = 1'b0;
        w_step         = 1'b0;

        if (w_tick_en && w_tick) begin
            if (r_per_cnt_q == r_period_q - PER_W'(1)) begin
                w_per_cnt_d = '0;
                w_step      = 1'b1;
            end else begin
                w_per_cnt_d = r_per_cnt_q + PER_W'(1);
            end
        end

        case (r_state_q)
            ST_IDLE: w_led_d = '0;
            ST_LOAD: begin
                w_led_d     = w_led_init;
                w_dir_d     = 1'b1;
                w_per_cnt_d = '0;
                w_state_d   = pause ? ST_HOLD : ST_RUN;
            end
            ST_RUN: begin
                if (w_step) begin
                    w_led_d        = w_led_next;
                    w_dir_d        = w_dir_next;
                    w_step_pulse_d = 1'b1;
                end
                if (pause) begin
                    w_state_d = ST_HOLD;
                end
            end
            default: begin
                if (!pause) begin
                    w_state_d = ST_RUN;
                end
            end
        endcase

        // A command accepted in the same cycle as a step suppresses the step.
        if (w_accept) begin
            w_step_pulse_d = 1'b0;
            w_led_d        = r_led_q;
            w_dir_d        = r_dir_q;
            if (mode_is_run(cmd_mode)) begin
                w_state_d  = ST_LOAD;
                w_mode_d   = cmd_mode;
                w_period_d = (cmd_period == '0) ? PER_W'(1) : cmd_period;
            end else begin
                w_state_d  = ST_IDLE;
                w_led_d    = '0;
            end
        end

        w_busy_d      = (w_state_d == ST_RUN) || (w_state_d == ST_HOLD);
        w_cmd_ready_d = (w_state_d != ST_LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_mode_q       <= MODE_STOP;
            r_period_q     <= PER_W'(1);
            r_per_cnt_q    <= '0;
            r_dir_q        <= 1'b1;
            r_led_q        <= '0;
            r_step_pulse_q <= 1'b0;
            r_busy_q       <= 1'b0;
            r_cmd_ready_q  <= 1'b1;
        end else begin
            r_state_q      <= w_state_d;
            r_mode_q       <= w_mode_d;
            r_period_q     <= w_period_d;
            r_per_cnt_q    <= w_per_cnt_d;
            r_dir_q        <= w_dir_d;
            r_led_q        <= w_led_d;
            r_step_pulse_q <= w_step_pulse_d;
            r_busy_q       <= w_busy_d;
            r_cmd_ready_q  <= w_cmd_ready_d;
        end
    end

    assign led        = r_led_q;
    assign step_pulse = r_step_pulse_q;
    assign busy       = r_busy_q;
    assign cmd_ready  = r_cmd_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_led_seq_ctrl
//  Description : Self-checking bench for led_seq_ctrl (1 tick = 10 clk).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_led_seq_ctrl;
    localparam int CLK_FREQ = 1000;
    localparam int TICK_HZ  = 100;
    localparam int DIV      = CLK_FREQ / TICK_HZ;
    localparam int LED_W    = 4;
    localparam int PER_W    = 16;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_RUN  = 2;
    localparam int P_HOLD = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_mode;
    logic [PER_W-1:0] cmd_period;
    logic             pause;
    logic [LED_W-1:0] led;
    logic             step_pulse;
    logic             busy;

    always #5 clk = ~clk;

    led_seq_ctrl #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ),
        .LED_W    (LED_W),
        .PER_W    (PER_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_period (cmd_period),
        .pause      (pause),
        .led        (led),
        .step_pulse (step_pulse),
        .busy       (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: phase, remaining cycles to next step, step index k.
    int         m_phase = P_IDLE;
    int         m_mode  = 0;
    int         m_per   = 1;
    int         m_rem   = 0;
    int         m_k     = 0;
    logic [3:0] m_led   = 4'h0;
    logic       m_pulse = 1'b0;
    logic       m_busy  = 1'b0;
    logic       m_ready = 1'b1;

    typedef struct {
        logic [2:0]  mode;
        logic [15:0] period;
        logic [3:0]  init;
        int          nsteps;
        int          interval;
        logic [63:0] seq;
    } vec_t;

    vec_t vec[5];

    function automatic logic [3:0] pat(input int mode, input int k);
        case (mode)
            1: return 4'(1 << (k % 4));
            2: return 4'(8 >> (k % 4));
            3: begin
                case (k % 6)
                    0: return 4'h1;
                    1: return 4'h2;
                    2: return 4'h4;
                    3: return 4'h8;
                    4: return 4'h4;
                    default: return 4'h2;
                endcase
            end
            4: return ((k % 2) == 0) ? 4'hF : 4'h0;
            5: return 4'(k % 16);
            default: return 4'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic acc;
        acc     = cmd_valid && m_ready;
        m_pulse = 1'b0;
        if (rst) begin
            m_phase = P_IDLE;
            m_led   = 4'h0;
            m_mode  = 0;
            m_per   = 1;
        end else if (acc) begin
            if (cmd_mode >= 3'd1 && cmd_mode <= 3'd5) begin
                m_phase = P_LOAD;
                m_mode  = int'(cmd_mode);
                m_per   = (cmd_period == 16'd0) ? 1 : int'(cmd_period);
            end else begin
                m_phase = P_IDLE;
                m_led   = 4'h0;
            end
        end else begin
            case (m_phase)
                P_IDLE: m_led = 4'h0;
                P_LOAD: begin
                    m_k     = 0;
                    m_led   = pat(m_mode, 0);
                    m_rem   = m_per * DIV;
                    m_phase = pause ? P_HOLD : P_RUN;
                end
                P_RUN: begin
                    if (pause) begin
                        m_phase = P_HOLD;
                    end else if (m_rem == 1) begin
                        m_k++;
                        m_led   = pat(m_mode, m_k);
                        m_pulse = 1'b1;
                        m_rem   = m_per * DIV;
                    end else begin
                        m_rem--;
                    end
                end
                default: if (!pause) m_phase = P_RUN;
            endcase
        end
        m_busy  = (m_phase == P_RUN) || (m_phase == P_HOLD);
        m_ready = (m_phase != P_LOAD);
    endtask

    task automatic tick_clk();
        @(posedge clk);
        model_step();
        #1;
        check("model_led",        32'(led),        32'(m_led));
        check("model_step_pulse", 32'(step_pulse), 32'(m_pulse));
        check("model_busy",       32'(busy),       32'(m_busy));
        check("model_cmd_ready",  32'(cmd_ready),  32'(m_ready));
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [2:0] mode, input logic [15:0] per);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 10) begin
            tick_clk();
            guard++;
        end
        if (!cmd_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL cmd_ready_timeout: got 0 expected 1");
        end
        cmd_valid  = 1'b1;
        cmd_mode   = mode;
        cmd_period = per;
        tick_clk();
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_pulse(input int limit, output int cycles);
        cycles = 0;
        do begin
            tick_clk();
            cycles++;
        end while (!step_pulse && cycles < limit);
        if (!step_pulse) begin
            n_cmp++;
            n_fail++;
            $display("FAIL pulse_timeout: got no step_pulse expected one within %0d cycles", limit);
            cycles = -1;
        end
    endtask

    initial begin
        int         cyc;
        bit         saw;
        logic [3:0] held;

        vec[0] = '{3'd1, 16'd2, 4'h1,  4, 20, 64'h1842};
        vec[1] = '{3'd3, 16'd1, 4'h1,  7, 10, 64'h2124842};
        vec[2] = '{3'd5, 16'd0, 4'h0, 16, 10, 64'h0FEDCBA987654321};
        vec[3] = '{3'd2, 16'd3, 4'h8,  4, 30, 64'h8124};
        vec[4] = '{3'd4, 16'd1, 4'hF,  4, 10, 64'hF0F0};

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_mode   = 3'd0;
        cmd_period = 16'd0;
        pause      = 1'b0;
        repeat (3) tick_clk();
        rst = 1'b0;

        // Idle after reset: nothing moves.
        saw = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick_clk();
            if (step_pulse) saw = 1'b1;
        end
        check("idle_led",      32'(led),       32'h0);
        check("idle_busy",     32'(busy),      32'h0);
        check("idle_ready",    32'(cmd_ready), 32'h1);
        check("idle_no_pulse", 32'(saw),       32'h0);

        for (int v = 0; v < 5; v++) begin
            send_cmd(vec[v].mode, vec[v].period);
            tick_clk();
            check($sformatf("v%0d_init", v), 32'(led), 32'(vec[v].init));
            check($sformatf("v%0d_busy", v), 32'(busy), 32'h1);
            for (int s = 0; s < vec[v].nsteps; s++) begin
                wait_pulse(2000, cyc);
                check($sformatf("v%0d_s%0d_interval", v, s), 32'(cyc), 32'(vec[v].interval));
                check($sformatf("v%0d_s%0d_led", v, s), 32'(led), 32'(vec[v].seq[s*4 +: 4]));
            end
        end

        // Pause mid-period in blink mode: remaining 15 counted cycles plus the HOLD exit cycle.
        send_cmd(3'd4, 16'd3);
        tick_clk();
        check("pause_init", 32'(led), 32'hF);
        repeat (15) tick_clk();
        pause = 1'b1;
        saw   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick_clk();
            if (step_pulse || led != 4'hF) saw = 1'b1;
        end
        check("pause_frozen", 32'(saw), 32'h0);
        check("pause_busy",   32'(busy), 32'h1);
        pause = 1'b0;
        wait_pulse(200, cyc);
        check("pause_resume_cycles", 32'(cyc), 32'd16);
        check("pause_resume_led",    32'(led), 32'h0);

        // Command lands in the same cycle the step fires.
        send_cmd(3'd1, 16'd1);
        tick_clk();
        wait_pulse(200, cyc);
        held = led;
        repeat (9) tick_clk();
        send_cmd(3'd2, 16'd1);
        check("collide_no_pulse", 32'(step_pulse), 32'h0);
        check("collide_led_held", 32'(led),        32'(held));
        tick_clk();
        check("collide_restart",  32'(led),        32'h8);

        // Reset mid-run, then a reserved mode.
        repeat (13) tick_clk();
        rst = 1'b1;
        tick_clk();
        rst = 1'b0;
        check("rst_led",   32'(led),       32'h0);
        check("rst_busy",  32'(busy),      32'h0);
        check("rst_ready", 32'(cmd_ready), 32'h1);
        send_cmd(3'd6, 16'd2);
        tick_clk();
        check("reserved_led",  32'(led),  32'h0);
        check("reserved_busy", 32'(busy), 32'h0);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 4000; i++) begin
            cmd_valid  = ($urandom_range(0, 59) == 0);
            cmd_mode   = 3'($urandom_range(0, 7));
            cmd_period = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) pause = ~pause;
            rst = ($urandom_range(0, 999) == 0);
            tick_clk();
        end
        rst       = 1'b0;
        cmd_valid = 1'b0;
        pause     = 1'b0;
        tick_clk();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
